if_scratch_read_ctrl: RTL

Read-side controller for the input-feature (IF) scratchpad. It consumes the writer's address counter (`last_write`) and issues sliding-window read addresses into the circular IF scratchpad. Window length and stride are programmable. It streams registered scratchpad data to the PE with valid/last flags, and exports its window base so the writer can throttle. It sits between the IF scratchpad top (writer side) and the PE datapath.

---
 rtl/if_scratch_read_ctrl_pkg.sv | 29 ++
 rtl/if_scratch_read_ctrl_if.sv | 25 ++
 rtl/if_window_counter.sv | 26 ++
 rtl/if_scratch_read_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/if_scratch_read_ctrl_pkg.sv
// Shared definitions for the IF scratchpad read controller: FSM state
// encodings and the circular-buffer occupancy helper.
package if_scratch_read_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT    = 3'd1;
    localparam logic [2:0] ST_READ    = 3'd2;
    localparam logic [2:0] ST_ADVANCE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WAIT    = ST_WAIT,
        S_READ    = ST_READ,
        S_ADVANCE = ST_ADVANCE,
        S_DONE    = ST_DONE
    } rd_state_t;

    // Words written but not yet released by the reader, modulo 2**aw.
    // Callers truncate the result to their address width.
    function automatic logic [31:0] occupancy(input logic [31:0] last_write,
                                              input logic [31:0] base,
                                              input int unsigned aw);
        logic [31:0] mask;
        mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
        return (last_write - base) & mask;
    endfunction

endpackage

// File: rtl/if_scratch_read_ctrl_if.sv
// Scratchpad-side and PE-side signals of the IF read controller.
// master = the controller, slave = scratchpad/writer/PE environment.
interface if_scratch_read_ctrl_if #(
    parameter int SCRATCH_WIDTH        = 8,
    parameter int SCRATCH_ADDRESS_SIZE = 8
);
    logic [SCRATCH_ADDRESS_SIZE-1:0] last_write;
    logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr;
    logic [SCRATCH_ADDRESS_SIZE-1:0] read_base;
    logic [SCRATCH_WIDTH-1:0]        scratch_dout;
    logic [SCRATCH_WIDTH-1:0]        win_data;
    logic                            cons_ready;
    logic                            win_valid;
    logic                            win_last;

    modport master (
        input  last_write, scratch_dout, cons_ready,
        output read_addr, read_base, win_data, win_valid, win_last
    );

    modport slave (
        output last_write, scratch_dout, cons_ready,
        input  read_addr, read_base, win_data, win_valid, win_last
    );
endinterface

// File: rtl/if_window_counter.sv
// Loadable up-counter with a terminal-count flag (count == limit-1).
// Used for the in-window offset and for the windows-per-job count.
module if_window_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);
    // Load has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + WIDTH'(1);
    end

    assign at_term = (count == (limit - WIDTH'(1)));
endmodule

// File: rtl/if_scratch_read_ctrl.sv
// Sliding-window read controller for the circular IF scratchpad.
// read_addr is registered and presented during the issue cycle, so the
// registered scratchpad data lines up with win_valid one cycle later.
module if_scratch_read_ctrl
    import if_scratch_read_ctrl_pkg::*;
#(
    parameter int SCRATCH_WIDTH        = 8,
    parameter int SCRATCH_ADDRESS_SIZE = 8,
    parameter int WIN_CNT_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] filter_size,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] stride,
    input  logic [WIN_CNT_WIDTH-1:0]        num_windows,
    if_scratch_read_ctrl_if.master          bus,
    output logic                            busy,
    output logic                            done
);
    localparam int AW = SCRATCH_ADDRESS_SIZE;
    localparam int CW = WIN_CNT_WIDTH;

    rd_state_t        state;
    logic [AW-1:0]    fs_q;
    logic [AW-1:0]    stride_q;
    logic [CW-1:0]    nw_q;
    logic [AW-1:0]    base;
    logic [AW-1:0]    read_addr_q;
    logic             win_valid_q;
    logic             win_last_q;

    logic [AW-1:0]    occ;
    logic [AW-1:0]    offset;
    logic             off_term;
    logic [CW-1:0]    win_cnt;
    logic             win_term;
    logic             rd_issue;
    logic             rd_last;
    logic             win_start;

    assign occ       = AW'(occupancy(32'(bus.last_write), 32'(base), AW));
    assign win_start = (state == S_WAIT) && (occ >= fs_q);
    assign rd_issue  = (state == S_READ) && bus.cons_ready;
    assign rd_last   = rd_issue && off_term;

    if_window_counter #(.WIDTH(AW)) u_offset (
        .clk      (clk),
        .rst      (rst),
        .load     (win_start),
        .load_val ('0),
        .en       (rd_issue),
        .limit    (fs_q),
        .count    (offset),
        .at_term  (off_term)
    );

    if_window_counter #(.WIDTH(CW)) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == S_IDLE) && start),
        .load_val ('0),
        .en       ((state == S_ADVANCE) && !win_term),
        .limit    (nw_q),
        .count    (win_cnt),
        .at_term  (win_term)
    );

    // Job FSM plus every registered output, including the latency-1 flag pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            fs_q        <= '0;
            stride_q    <= '0;
            nw_q        <= '0;
            base        <= '0;
            read_addr_q <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            win_valid_q <= rd_issue;
            win_last_q  <= rd_last;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fs_q     <= filter_size;
                        stride_q <= stride;
                        nw_q     <= num_windows;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Preload offset 0 so the first read issues on entry to READ.
                    if (win_start) begin
                        read_addr_q <= base;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        if (off_term)
                            state <= S_ADVANCE;
                        else
                            read_addr_q <= base + offset + AW'(1);
                    end
                end
                S_ADVANCE: begin
                    base <= base + stride_q;
                    if (win_term) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.read_addr = read_addr_q;
    assign bus.read_base = base;
    assign bus.win_data  = bus.scratch_dout;
    assign bus.win_valid = win_valid_q;
    assign bus.win_last  = win_last_q;

    logic unused_ok;
    assign unused_ok = ^win_cnt;
endmodule
